// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM pipeline register.
//   ex_mem_ctrl_t  : memory/writeback control bundle (wb, mem_read, mem_write, mem2reg)
//   ex_mem_entry_t : one full pipeline entry at the default widths
//   MAX_DEPTH      : largest supported number of register stages
//   EX_MEM_CTRL_W  : packed width of ex_mem_ctrl_t
//   gate_ctrl()    : forces side-effecting controls low for an invalid entry
package ex_mem_pkg;

  localparam int MAX_DEPTH      = 4;
  localparam int EX_MEM_CTRL_W  = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_BE_W       = DEF_DATA_W / 8;

  typedef struct packed {
    logic wb;
    logic mem_read;
    logic mem_write;
    logic mem2reg;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic                      valid;
    ex_mem_ctrl_t              ctrl;
    logic [DEF_BE_W-1:0]       byte_en;
    logic [DEF_DATA_W-1:0]     wdata;
    logic [DEF_DATA_W-1:0]     alu_result;
    logic [DEF_REG_ADDR_W-1:0] dst_addr;
  } ex_mem_entry_t;

  // mem2reg only steers the writeback mux; it cannot cause a side effect on
  // its own, so it is left ungated.
  function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t c, input logic valid);
    ex_mem_ctrl_t g;
    g.wb        = c.wb & valid;
    g.mem_read  = c.mem_read & valid;
    g.mem_write = c.mem_write & valid;
    g.mem2reg   = c.mem2reg;
    return g;
  endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: one EX/MEM entry register.
// Priority on each rising edge: rst (clear all) > flush (clear valid only)
// > stall (hold) > capture upstream entry.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall, flush        : hold / invalidate controls
//   up_*                : entry offered by the previous stage (or EX)
//   valid, ctrl, byte_en, wdata, alu_result, dst_addr : registered entry
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     up_valid,
  input  logic [EX_MEM_CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W/8-1:0]      up_byte_en,
  input  logic [DATA_W-1:0]        up_wdata,
  input  logic [DATA_W-1:0]        up_alu_result,
  input  logic [REG_ADDR_W-1:0]    up_dst_addr,
  output logic                     valid,
  output logic [EX_MEM_CTRL_W-1:0] ctrl,
  output logic [DATA_W/8-1:0]      byte_en,
  output logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        alu_result,
  output logic [REG_ADDR_W-1:0]    dst_addr
);

  logic                     valid_reg;
  logic [EX_MEM_CTRL_W-1:0] ctrl_reg;
  logic [DATA_W/8-1:0]      byte_en_reg;
  logic [DATA_W-1:0]        wdata_reg;
  logic [DATA_W-1:0]        alu_result_reg;
  logic [REG_ADDR_W-1:0]    dst_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      ctrl_reg       <= '0;
      byte_en_reg    <= '0;
      wdata_reg      <= '0;
      alu_result_reg <= '0;
      dst_addr_reg   <= '0;
    end else if (flush) begin
      // Only the valid bit matters for a squash; the datapath may go stale
      // because every side-effecting output is gated by valid downstream.
      valid_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg      <= up_valid;
      ctrl_reg       <= up_ctrl;
      byte_en_reg    <= up_byte_en;
      wdata_reg      <= up_wdata;
      alu_result_reg <= up_alu_result;
      dst_addr_reg   <= up_dst_addr;
    end
  end

  assign valid      = valid_reg;
  assign ctrl       = ctrl_reg;
  assign byte_en    = byte_en_reg;
  assign wdata      = wdata_reg;
  assign alu_result = alu_result_reg;
  assign dst_addr   = dst_addr_reg;

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: DEPTH-stage EX/MEM pipeline register with stall/flush.
// Latency is DEPTH rising edges when not stalled. wb/mem_read/mem_write and
// byte enables are forced low whenever the final stage holds a bubble.
// Optional feature macro: EX_MEM_PERF_CNT_EN (stall and bubble counters,
// saturating). When undefined the counter ports read 0 and carry no flops.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   stall, flush                    : hold all stages / invalidate all stages
//   valid_in, *_in                  : entry from EX
//   valid_out, *_out                : entry in the last stage (controls gated)
//   stall_cnt_out, bubble_cnt_out   : performance counters
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem2reg_in,
  input  logic [DATA_W/8-1:0]   mem_byte_en_in,
  input  logic [DATA_W-1:0]     mem_write_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] dst_addr_in,
  output logic                  valid_out,
  output logic                  wb_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  mem2reg_out,
  output logic [DATA_W/8-1:0]   mem_byte_en_out,
  output logic [DATA_W-1:0]     mem_write_data_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] dst_addr_out,
  output logic [CNT_W-1:0]      stall_cnt_out,
  output logic [CNT_W-1:0]      bubble_cnt_out
);

  localparam int BE_W = DATA_W / 8;

  generate
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $fatal(1, "ex_mem_pipe: DEPTH must be in 1..%0d", MAX_DEPTH);
    end
    if ($bits(ex_mem_ctrl_t) != EX_MEM_CTRL_W) begin : g_bad_ctrl_w
      $fatal(1, "ex_mem_pipe: ex_mem_ctrl_t width mismatch");
    end
  endgenerate

  // Index 0 is the EX-side input; index k is the output of stage k-1.
  logic                     chain_valid      [DEPTH+1];
  logic [EX_MEM_CTRL_W-1:0] chain_ctrl       [DEPTH+1];
  logic [BE_W-1:0]          chain_byte_en    [DEPTH+1];
  logic [DATA_W-1:0]        chain_wdata      [DEPTH+1];
  logic [DATA_W-1:0]        chain_alu_result [DEPTH+1];
  logic [REG_ADDR_W-1:0]    chain_dst_addr   [DEPTH+1];

  ex_mem_ctrl_t ctrl_in;
  assign ctrl_in = '{wb: wb_in, mem_read: mem_read_in,
                     mem_write: mem_write_in, mem2reg: mem2reg_in};

  assign chain_valid[0]      = valid_in;
  assign chain_ctrl[0]       = ctrl_in;
  assign chain_byte_en[0]    = mem_byte_en_in;
  assign chain_wdata[0]      = mem_write_data_in;
  assign chain_alu_result[0] = alu_result_in;
  assign chain_dst_addr[0]   = dst_addr_in;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      ex_mem_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
      ) u_stage (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .up_valid      (chain_valid[gi]),
        .up_ctrl       (chain_ctrl[gi]),
        .up_byte_en    (chain_byte_en[gi]),
        .up_wdata      (chain_wdata[gi]),
        .up_alu_result (chain_alu_result[gi]),
        .up_dst_addr   (chain_dst_addr[gi]),
        .valid         (chain_valid[gi+1]),
        .ctrl          (chain_ctrl[gi+1]),
        .byte_en       (chain_byte_en[gi+1]),
        .wdata         (chain_wdata[gi+1]),
        .alu_result    (chain_alu_result[gi+1]),
        .dst_addr      (chain_dst_addr[gi+1])
      );
    end
  endgenerate

  logic         last_valid;
  ex_mem_ctrl_t last_ctrl;
  ex_mem_ctrl_t gated_ctrl;

  assign last_valid = chain_valid[DEPTH];
  assign last_ctrl  = ex_mem_ctrl_t'(chain_ctrl[DEPTH]);
  assign gated_ctrl = gate_ctrl(last_ctrl, last_valid);

  assign valid_out          = last_valid;
  assign wb_out             = gated_ctrl.wb;
  assign mem_read_out       = gated_ctrl.mem_read;
  assign mem_write_out      = gated_ctrl.mem_write;
  assign mem2reg_out        = gated_ctrl.mem2reg;
  assign mem_byte_en_out    = chain_byte_en[DEPTH] & {BE_W{last_valid}};
  assign mem_write_data_out = chain_wdata[DEPTH];
  assign alu_result_out     = chain_alu_result[DEPTH];
  assign dst_addr_out       = chain_dst_addr[DEPTH];

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Both counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      // A bubble is counted when the final stage is empty and the pipe moves.
      if (!stall && !last_valid && (bubble_cnt_reg != '1)) begin
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_out  = stall_cnt_reg;
  assign bubble_cnt_out = bubble_cnt_reg;
`else
  assign stall_cnt_out  = '0;
  assign bubble_cnt_out = '0;
`endif

endmodule
